// File: rtl/sevenseg_capture.sv
// Readback monitor for a multiplexed active-low 7-segment display: waits for each
// digit's pattern to settle, decodes it back to a hex nibble and hands out full frames.
module sevenseg_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_value,
    output logic              bad_pat,
    output logic              overrun
);

    localparam int CW   = $clog2(STABLE_CYC + 1);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int ZW   = $clog2(NDIG + 1);

    logic [6:0]        r_seg, p_seg;
    logic [NDIG-1:0]   r_dig, p_dig;
    logic [CW-1:0]     cnt;
    logic [NDIG-1:0]   got;
    logic [4*NDIG-1:0] nib;

    logic              sample_evt;
    logic              frame_done;
    logic              dec_ok;
    logic [3:0]        dec_nib;
    logic [ZW-1:0]     zero_cnt;
    logic [IDXW-1:0]   zero_idx;
    logic              one_digit;

    // Inverse of the display decoder; anything off-table is flagged as a bad pattern.
    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (r_seg)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h58: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        zero_cnt = '0;
        zero_idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (!r_dig[k]) begin
                zero_cnt = zero_cnt + ZW'(1);
                zero_idx = k[IDXW-1:0];
            end
        end
    end

    assign one_digit  = (zero_cnt == ZW'(1));
    // Fires once per dwell: the registered value has now been identical STABLE_CYC cycles.
    assign sample_evt = (r_seg == p_seg) && (r_dig == p_dig) && (cnt == CW'(STABLE_CYC - 2));
    assign frame_done = &got;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg     <= '0;
            r_dig     <= '0;
            p_seg     <= '0;
            p_dig     <= '0;
            cnt       <= '0;
            got       <= '0;
            nib       <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            bad_pat   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_seg   <= seg_in;
            r_dig   <= dig_in;
            p_seg   <= r_seg;
            p_dig   <= r_dig;
            bad_pat <= 1'b0;

            if ((r_seg != p_seg) || (r_dig != p_dig))
                cnt <= '0;
            else if (cnt != CW'(STABLE_CYC))
                cnt <= cnt + CW'(1);

            if (frame_done)
                got <= '0;

            // A sample in the completion cycle belongs to the next frame, so it wins over the clear.
            if (sample_evt && one_digit) begin
                got[zero_idx] <= dec_ok;
                if (dec_ok)
                    nib[4*zero_idx +: 4] <= dec_nib;
                else
                    bad_pat <= 1'b1;
            end

            if (frame_done) begin
                if (!out_valid || out_ready) begin
                    out_value <= nib;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed scoreboard bench for sevenseg_capture: stimulus pushes expected frames,
// a monitor pops and compares them on every accepted handshake.
module tb_sevenseg_capture;

    logic        clk;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  dig_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_value;
    logic        bad_pat;
    logic        overrun;

    int          errors = 0;
    int          checks = 0;
    int          bad_high = 0;
    logic [15:0] exp_q[$];

    sevenseg_capture #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk(clk),
        .reset(reset),
        .seg_in(seg_in),
        .dig_in(dig_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .bad_pat(bad_pat),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: segOf = 7'h40;  4'h1: segOf = 7'h79;  4'h2: segOf = 7'h24;  4'h3: segOf = 7'h30;
            4'h4: segOf = 7'h19;  4'h5: segOf = 7'h12;  4'h6: segOf = 7'h02;  4'h7: segOf = 7'h58;
            4'h8: segOf = 7'h00;  4'h9: segOf = 7'h10;  4'hA: segOf = 7'h08;  4'hB: segOf = 7'h03;
            4'hC: segOf = 7'h46;  4'hD: segOf = 7'h21;  4'hE: segOf = 7'h06;  default: segOf = 7'h0E;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Inputs change 1 ns after a rising edge and are held for n sampling edges.
    task automatic applyStimulus(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in = s;
        dig_in = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic showDigit(input int k, input logic [3:0] v, input int n);
        applyStimulus(segOf(v), ~(4'b0001 << k), n);
    endtask

    task automatic blank(input int n);
        applyStimulus(7'h7F, 4'hF, n);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n > 0) #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: %0d frame(s) not delivered within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bad_pat) bad_high++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame: got %h, expected no frame", out_value);
            end else begin
                checkOutput("frame", out_value, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        seg_in    = 7'h7F;
        dig_in    = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_valid",   {15'd0, out_valid}, 16'd0);
        checkOutput("reset_value",   out_value,          16'h0000);
        checkOutput("reset_bad_pat", {15'd0, bad_pat},   16'd0);
        checkOutput("reset_overrun", {15'd0, overrun},   16'd0);

        $display("[TB] test 1: basic scan");
        exp_q.push_back(16'h4321);
        showDigit(0, 4'h1, 8); showDigit(1, 4'h2, 8); showDigit(2, 4'h3, 8); showDigit(3, 4'h4, 8);
        blank(4);
        waitDrain("t1_drain", 50);
        checkOutput("t1_valid_drop", {15'd0, out_valid}, 16'd0);

        $display("[TB] test 2: short dwell");
        showDigit(0, 4'h5, 3); showDigit(1, 4'h6, 3); showDigit(2, 4'h7, 3); showDigit(3, 4'h8, 3);
        blank(8);
        checkOutput("t2_valid",   {15'd0, out_valid}, 16'd0);
        checkOutput("t2_bad_cnt", bad_high[15:0],     16'd0);

        $display("[TB] test 3: bad pattern");
        showDigit(0, 4'hA, 8); showDigit(1, 4'hB, 8);
        applyStimulus(7'h7F, 4'b1011, 8);
        showDigit(3, 4'hD, 8);
        blank(6);
        checkOutput("t3_bad_cnt", bad_high[15:0],     16'd1);
        checkOutput("t3_no_frame", {15'd0, out_valid}, 16'd0);
        exp_q.push_back(16'hDCBA);
        showDigit(2, 4'hC, 8);
        blank(4);
        waitDrain("t3_drain", 50);

        $display("[TB] test 5: accept on completion cycle");
        out_ready = 1'b0;
        exp_q.push_back(16'h9876);
        exp_q.push_back(16'hDEF0);
        showDigit(0, 4'h6, 8); showDigit(1, 4'h7, 8); showDigit(2, 4'h8, 8); showDigit(3, 4'h9, 8);
        blank(4);
        checkOutput("t5_first_valid", {15'd0, out_valid}, 16'd1);
        showDigit(0, 4'h0, 8); showDigit(1, 4'hF, 8); showDigit(2, 4'hE, 8);
        seg_in = segOf(4'hD);
        dig_in = 4'b0111;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5_valid_held", {15'd0, out_valid}, 16'd1);
        checkOutput("t5_value",      out_value,          16'hDEF0);
        checkOutput("t5_overrun",    {15'd0, overrun},   16'd0);
        out_ready = 1'b1;
        waitDrain("t5_drain", 20);
        blank(2);

        $display("[TB] test 4: overrun");
        out_ready = 1'b0;
        showDigit(0, 4'h4, 8); showDigit(1, 4'h3, 8); showDigit(2, 4'h2, 8); showDigit(3, 4'h1, 8);
        showDigit(0, 4'h8, 8); showDigit(1, 4'h7, 8); showDigit(2, 4'h6, 8); showDigit(3, 4'h5, 8);
        blank(4);
        checkOutput("t4_overrun", {15'd0, overrun},   16'd1);
        checkOutput("t4_valid",   {15'd0, out_valid}, 16'd1);
        checkOutput("t4_held",    out_value,          16'h1234);
        exp_q.push_back(16'h1234);
        out_ready = 1'b1;
        waitDrain("t4_drain", 20);
        blank(2);
        checkOutput("t4_valid_drop",    {15'd0, out_valid}, 16'd0);
        checkOutput("t4_overrun_stick", {15'd0, overrun},   16'd1);

        $display("[TB] test 6: reset mid-frame");
        showDigit(0, 4'h9, 8); showDigit(1, 4'h9, 8);
        reset = 1'b1;
        blank(2);
        reset = 1'b0;
        checkOutput("t6_reset_value",   out_value,        16'h0000);
        checkOutput("t6_reset_overrun", {15'd0, overrun}, 16'd0);
        showDigit(2, 4'h0, 8); showDigit(3, 4'h5, 8);
        blank(6);
        checkOutput("t6_partial", {15'd0, out_valid}, 16'd0);
        exp_q.push_back(16'h50FE);
        showDigit(0, 4'hE, 8); showDigit(1, 4'hF, 8);
        blank(4);
        waitDrain("t6_drain", 50);
        checkOutput("final_bad_cnt", bad_high[15:0], 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
